cfg_fifo_anysize: RTL and testbench
===================================

CFG_FIFO_ANYSIZE -- requirements
Module: cfg_fifo_anysize

Interface
REQ-001 SHALL have parameter FIFO_SIZE, default 8, depth in entries; any integer >= 2, power of 2 not required.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, data bus width.
REQ-003 SHALL have parameter FWFT, default 0; 0 = standard 1-cycle read latency, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_LVL, default FIFO_SIZE-1, almost-full threshold in entries.
REQ-005 SHALL have parameter AEMPTY_LVL, default 1, almost-empty threshold in entries.
REQ-006 SHALL have ports: i_clk in 1 clock; i_rst_n in 1 reset, synchronous, active-low; i_ena in 1 global enable; i_flush in 1 synchronous clear; i_wr_req in 1 write request; i_data in DATA_WIDTH write data; i_rd_req in 1 read request (FWFT=1: pop acknowledge).
REQ-007 SHALL have outputs: o_data DATA_WIDTH read data; o_valid 1 data qualifier; o_full 1; o_empty 1; o_ready 1 (= !o_full); o_almost_full 1; o_almost_empty 1; o_current_sz $clog2(FIFO_SIZE+1) fill level; o_overflow 1 sticky; o_underflow 1 sticky.

Function
REQ-008 SHALL decode o_full = (count == FIFO_SIZE), o_empty = (count == 0), o_almost_full = (count >= AFULL_LVL), o_almost_empty = (count <= AEMPTY_LVL), all combinational from registered count.
REQ-009 SHALL accept a read when do_read = i_ena && i_rd_req && !o_empty.
REQ-010 SHALL accept a write when do_write = i_ena && i_wr_req && (!o_full || do_read); a write to a full FIFO with a same-cycle accepted read is accepted.
REQ-011 SHALL wrap rd/wr pointers from FIFO_SIZE-1 to 0; never index outside 0..FIFO_SIZE-1.
REQ-012 SHALL update count +1 on write-only, -1 on read-only, unchanged on both or neither.
REQ-013 FWFT=0: on do_read, o_data SHALL load the head entry and o_valid SHALL be 1 in the next cycle; o_valid SHALL be 0 after any enabled cycle without do_read; o_data holds otherwise.
REQ-014 FWFT=1: o_data SHALL present the head entry and o_valid = !o_empty, combinationally from registers; do_read pops the head; a write into an empty FIFO appears with o_valid=1 one cycle after the write.
REQ-015 Read and write to empty FIFO in the same cycle: read SHALL be rejected, write accepted, count becomes 1.
REQ-016 i_flush=1 with i_ena=1 SHALL zero pointers and count and set o_valid=0 next cycle; same-cycle wr/rd requests are dropped; o_data holds; sticky flags are unaffected.
REQ-017 i_ena=0 SHALL hold all state, including o_valid and o_data; requests and i_flush are ignored.
REQ-018 Storage SHALL be inferred memory, not reset.

Reset
REQ-019 i_rst_n=0 at a clock edge SHALL clear pointers, count, o_data, o_valid, o_overflow and o_underflow, with priority over i_ena and i_flush.
REQ-020 After reset: o_empty=1, o_almost_empty=1, o_full=0, o_ready=1, o_current_sz=0.
REQ-021 Reset mid-operation SHALL discard all contents; the first read after reset sees only post-reset writes.

Configuration
REQ-022 With macro CFG_FIFO_ERR_FLAGS_EN defined: o_overflow SHALL set on an enabled cycle with i_wr_req && !do_write; o_underflow SHALL set on an enabled cycle with i_rd_req && o_empty; both stay set until reset.
REQ-023 Without CFG_FIFO_ERR_FLAGS_EN: o_overflow and o_underflow SHALL be tied 0 with no flag registers.

Verification
REQ-024 SIZE=5, FWFT=0: write 5 words A0..A4 -> o_full=1, o_current_sz=5; 6th write is dropped; 5 reads return A0..A4 with o_valid one cycle after each request.
REQ-025 SIZE=5, full: assert wr and rd together with data B0 -> A0 read out, count stays 5; after draining, B0 is the last word out (wrap verified).
REQ-026 FWFT=1, empty: write C0 -> next cycle o_valid=1, o_data=C0 with no rd_req; rd_req pops it -> o_empty=1.
REQ-027 AFULL_LVL=4, AEMPTY_LVL=1, SIZE=5: fill 0->5 -> o_almost_empty high at count 0 and 1 only; o_almost_full high at count 4 and 5 only.
REQ-028 Count 3 with i_flush=1 and i_wr_req=1 -> count 0, o_valid=0 next cycle, write discarded; i_ena=0 for 3 cycles with requests -> state unchanged.
REQ-029 With CFG_FIFO_ERR_FLAGS_EN: read when empty -> o_underflow=1; write when full without read -> o_overflow=1; both persist through flush and clear only on i_rst_n=0.

Source files
------------

// File: rtl/cfg_fifo_anysize.sv
// Synchronous FIFO of any depth >= 2, with standard or first-word-fall-through read and level flags.
// Optional sticky overflow/underflow flags are built when CFG_FIFO_ERR_FLAGS_EN is defined.
module cfg_fifo_anysize #(
  parameter int FIFO_SIZE  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int FWFT       = 0,
  parameter int AFULL_LVL  = FIFO_SIZE - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_ena,
  input  logic                           i_flush,
  input  logic                           i_wr_req,
  input  logic [DATA_WIDTH-1:0]          i_data,
  input  logic                           i_rd_req,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_valid,
  output logic                           o_full,
  output logic                           o_empty,
  output logic                           o_ready,
  output logic                           o_almost_full,
  output logic                           o_almost_empty,
  output logic [$clog2(FIFO_SIZE+1)-1:0] o_current_sz,
  output logic                           o_overflow,
  output logic                           o_underflow
);

  localparam int CNT_W = $clog2(FIFO_SIZE + 1);
  localparam int PTR_W = (FIFO_SIZE > 2) ? $clog2(FIFO_SIZE) : 1;

  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(FIFO_SIZE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_SIZE);
  localparam logic [CNT_W-1:0] AFULL_CNT  = CNT_W'(AFULL_LVL);
  localparam logic [CNT_W-1:0] AEMPTY_CNT = CNT_W'(AEMPTY_LVL);

  logic [DATA_WIDTH-1:0] mem [FIFO_SIZE];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  do_read;
  logic                  do_write;
  logic                  accept_rd;
  logic                  accept_wr;

  assign o_full         = (count == FULL_CNT);
  assign o_empty        = (count == '0);
  assign o_ready        = !o_full;
  assign o_almost_full  = (count >= AFULL_CNT);
  assign o_almost_empty = (count <= AEMPTY_CNT);
  assign o_current_sz   = count;

  // A full FIFO still takes a write when the same cycle pops an entry.
  assign do_read   = i_ena && i_rd_req && !o_empty;
  assign do_write  = i_ena && i_wr_req && (!o_full || do_read);
  assign accept_rd = do_read && !i_flush;
  assign accept_wr = do_write && !i_flush;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (i_ena) begin
      if (i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept_wr) wr_ptr <= ptr_inc(wr_ptr);
        if (accept_rd) rd_ptr <= ptr_inc(rd_ptr);
        case ({accept_wr, accept_rd})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: storage has no reset so it maps onto RAM; the pointers alone define which entries are live.
  always_ff @(posedge i_clk) begin
    if (accept_wr) mem[wr_ptr] <= i_data;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else if (i_ena) begin
          valid_q <= accept_rd;
          if (accept_rd) data_q <= mem[rd_ptr];
        end
      end

      assign o_data  = data_q;
      assign o_valid = valid_q;
    end else begin : g_fwft_read
      // Head entry is presented directly; masked to zero while nothing is stored.
      assign o_valid = !o_empty;
      assign o_data  = o_valid ? mem[rd_ptr] : '0;
    end
  endgenerate

`ifdef CFG_FIFO_ERR_FLAGS_EN
  logic overflow_q;
  logic underflow_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (i_ena) begin
      if (i_wr_req && !do_write) overflow_q  <= 1'b1;
      if (i_rd_req && o_empty)   underflow_q <= 1'b1;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_fifo_anysize.sv
// Bench for cfg_fifo_anysize: a standard-read and an FWFT instance share stimulus and are
// compared against a queue-based reference model, plus a directed vector table.
module tb_cfg_fifo_anysize;

  localparam int SIZE = 5;
  localparam int DW   = 16;
  localparam int AF   = 4;
  localparam int AE   = 1;
  localparam int CW   = $clog2(SIZE + 1);

  logic          clk = 1'b0;
  logic          rst_n, ena, flush, wr, rd;
  logic [DW-1:0] din;

  logic [DW-1:0] d0_data, d1_data;
  logic          d0_valid, d0_full, d0_empty, d0_ready, d0_af, d0_ae, d0_ov, d0_un;
  logic          d1_valid, d1_full, d1_empty, d1_ready, d1_af, d1_ae, d1_ov, d1_un;
  logic [CW-1:0] d0_sz, d1_sz;

  always #5 clk = ~clk;

  cfg_fifo_anysize #(.FIFO_SIZE(SIZE), .DATA_WIDTH(DW), .FWFT(0), .AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_flush(flush), .i_wr_req(wr), .i_data(din),
    .i_rd_req(rd), .o_data(d0_data), .o_valid(d0_valid), .o_full(d0_full), .o_empty(d0_empty),
    .o_ready(d0_ready), .o_almost_full(d0_af), .o_almost_empty(d0_ae), .o_current_sz(d0_sz),
    .o_overflow(d0_ov), .o_underflow(d0_un)
  );

  cfg_fifo_anysize #(.FIFO_SIZE(SIZE), .DATA_WIDTH(DW), .FWFT(1), .AFULL_LVL(AF), .AEMPTY_LVL(AE)) dut_fw (
    .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .i_flush(flush), .i_wr_req(wr), .i_data(din),
    .i_rd_req(rd), .o_data(d1_data), .o_valid(d1_valid), .o_full(d1_full), .o_empty(d1_empty),
    .o_ready(d1_ready), .o_almost_full(d1_af), .o_almost_empty(d1_ae), .o_current_sz(d1_sz),
    .o_overflow(d1_ov), .o_underflow(d1_un)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a queue, plus the standard-read output register and sticky flags.
  logic [DW-1:0] q[$];
  logic          m_vld;
  logic [DW-1:0] m_dat;
  logic          m_ov, m_un;

  typedef struct {
    logic          rst_n, ena, flush, wr, rd;
    logic [DW-1:0] din;
    int            exp_cnt;
    logic          exp_vld;
    logic [DW-1:0] exp_dat;
    logic [3:0]    exp_flags;  // {full, empty, almost_full, almost_empty}
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_update(input logic r, e, f, w, rq, input logic [DW-1:0] d);
    bit was_empty, rd_ok, wr_ok;
    if (!r) begin
      q.delete();
      m_vld = 1'b0;
      m_dat = '0;
      m_ov  = 1'b0;
      m_un  = 1'b0;
    end else if (e) begin
      was_empty = (q.size() == 0);
      rd_ok     = rq && !was_empty;
      wr_ok     = w && (q.size() < SIZE || rd_ok);
`ifdef CFG_FIFO_ERR_FLAGS_EN
      if (w && !wr_ok) m_ov = 1'b1;
      if (rq && was_empty) m_un = 1'b1;
`endif
      if (f) begin
        q.delete();
        m_vld = 1'b0;
      end else begin
        m_vld = rd_ok;
        if (rd_ok) m_dat = q.pop_front();
        if (wr_ok) q.push_back(d);
      end
    end
  endtask

  task automatic compare_all(input string tag);
    int n;
    n = q.size();
    check({tag, " sz"},        32'(d0_sz), 32'(n));
    check({tag, " full"},      32'(d0_full), 32'(n == SIZE));
    check({tag, " empty"},     32'(d0_empty), 32'(n == 0));
    check({tag, " ready"},     32'(d0_ready), 32'(n != SIZE));
    check({tag, " afull"},     32'(d0_af), 32'(n >= AF));
    check({tag, " aempty"},    32'(d0_ae), 32'(n <= AE));
    check({tag, " valid"},     32'(d0_valid), 32'(m_vld));
    check({tag, " data"},      32'(d0_data), 32'(m_dat));
    check({tag, " fw sz"},     32'(d1_sz), 32'(n));
    check({tag, " fw valid"},  32'(d1_valid), 32'(n != 0));
    if (n != 0) check({tag, " fw data"}, 32'(d1_data), 32'(q[0]));
    check({tag, " overflow"},  32'({d0_ov, d1_ov}), 32'({m_ov, m_ov}));
    check({tag, " underflow"}, 32'({d0_un, d1_un}), 32'({m_un, m_un}));
  endtask

  task automatic step(input string tag, input logic r, e, f, w, rq, input logic [DW-1:0] d);
    rst_n = r; ena = e; flush = f; wr = w; rd = rq; din = d;
    @(posedge clk);
    model_update(r, e, f, w, rq, d);
    #1;
    compare_all(tag);
  endtask

  function automatic vec_t mk(input logic r, e, f, w, rq, input logic [DW-1:0] d,
                              input int cnt, input logic vld, input logic [DW-1:0] dat,
                              input logic [3:0] flg);
    vec_t v;
    v.rst_n = r; v.ena = e; v.flush = f; v.wr = w; v.rd = rq; v.din = d;
    v.exp_cnt = cnt; v.exp_vld = vld; v.exp_dat = dat; v.exp_flags = flg;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; ena = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
    m_vld = 1'b0; m_dat = '0; m_ov = 1'b0; m_un = 1'b0;

    //            rst ena fl  wr  rd  din       cnt vld dat       {full,empty,af,ae}
    vecs[0]  = mk(0,  1,  1,  1,  1,  16'h0000, 0,  0,  16'h0000, 4'b0101);
    vecs[1]  = mk(1,  1,  0,  1,  0,  16'hA000, 1,  0,  16'h0000, 4'b0001);
    vecs[2]  = mk(1,  1,  0,  1,  0,  16'hA001, 2,  0,  16'h0000, 4'b0000);
    vecs[3]  = mk(1,  1,  0,  1,  0,  16'hA002, 3,  0,  16'h0000, 4'b0000);
    vecs[4]  = mk(1,  1,  0,  1,  0,  16'hA003, 4,  0,  16'h0000, 4'b0010);
    vecs[5]  = mk(1,  1,  0,  1,  0,  16'hA004, 5,  0,  16'h0000, 4'b1010);
    vecs[6]  = mk(1,  1,  0,  1,  0,  16'hA005, 5,  0,  16'h0000, 4'b1010);
    vecs[7]  = mk(1,  1,  0,  1,  1,  16'hB000, 5,  1,  16'hA000, 4'b1010);
    vecs[8]  = mk(1,  1,  0,  0,  1,  16'h0000, 4,  1,  16'hA001, 4'b0010);
    vecs[9]  = mk(1,  1,  0,  0,  1,  16'h0000, 3,  1,  16'hA002, 4'b0000);
    vecs[10] = mk(1,  1,  0,  0,  1,  16'h0000, 2,  1,  16'hA003, 4'b0000);
    vecs[11] = mk(1,  1,  0,  0,  1,  16'h0000, 1,  1,  16'hA004, 4'b0001);
    vecs[12] = mk(1,  1,  0,  0,  1,  16'h0000, 0,  1,  16'hB000, 4'b0101);
    vecs[13] = mk(1,  1,  0,  0,  0,  16'h0000, 0,  0,  16'hB000, 4'b0101);
    vecs[14] = mk(1,  1,  0,  1,  1,  16'hD000, 1,  0,  16'hB000, 4'b0001);
    vecs[15] = mk(1,  1,  0,  1,  0,  16'hD001, 2,  0,  16'hB000, 4'b0000);
    vecs[16] = mk(1,  1,  0,  1,  0,  16'hD002, 3,  0,  16'hB000, 4'b0000);
    vecs[17] = mk(1,  1,  1,  1,  0,  16'hD003, 0,  0,  16'hB000, 4'b0101);
    vecs[18] = mk(1,  1,  0,  1,  0,  16'hE000, 1,  0,  16'hB000, 4'b0001);
    vecs[19] = mk(1,  0,  1,  1,  1,  16'hE001, 1,  0,  16'hB000, 4'b0001);
    vecs[20] = mk(1,  0,  0,  1,  0,  16'hE002, 1,  0,  16'hB000, 4'b0001);
    vecs[21] = mk(1,  0,  0,  0,  1,  16'h0000, 1,  0,  16'hB000, 4'b0001);
    vecs[22] = mk(1,  1,  0,  0,  1,  16'h0000, 0,  1,  16'hE000, 4'b0101);
    vecs[23] = mk(1,  0,  0,  1,  1,  16'hE003, 0,  1,  16'hE000, 4'b0101);
    vecs[24] = mk(1,  1,  0,  0,  0,  16'h0000, 0,  0,  16'hE000, 4'b0101);

    for (int i = 0; i < 25; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst_n, vecs[i].ena, vecs[i].flush,
           vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d tbl sz", i),    32'(d0_sz), 32'(vecs[i].exp_cnt));
      check($sformatf("vec%0d tbl valid", i), 32'(d0_valid), 32'(vecs[i].exp_vld));
      check($sformatf("vec%0d tbl data", i),  32'(d0_data), 32'(vecs[i].exp_dat));
      check($sformatf("vec%0d tbl flags", i), 32'({d0_full, d0_empty, d0_af, d0_ae}),
            32'(vecs[i].exp_flags));
    end

    // FWFT: a write into an empty FIFO is visible next cycle without a read request.
    step("fwft wr", 1, 1, 0, 1, 0, 16'hC000);
    check("fwft head valid", 32'(d1_valid), 32'(1));
    check("fwft head data",  32'(d1_data), 32'h0000C000);
    step("fwft pop", 1, 1, 0, 0, 1, 16'h0000);
    check("fwft popped empty", 32'(d1_empty), 32'(1));

    // Reset mid-operation discards stored words.
    step("pre rst wr0", 1, 1, 0, 1, 0, 16'h1111);
    step("pre rst wr1", 1, 1, 0, 1, 0, 16'h2222);
    step("mid rst",     0, 1, 0, 1, 1, 16'h3333);
    check("mid rst empty", 32'({d0_empty, d1_empty}), 32'(2'b11));
    step("post rst wr", 1, 1, 0, 1, 0, 16'hF000);
    step("post rst rd", 1, 1, 0, 0, 1, 16'h0000);
    check("post rst first word", 32'(d0_data), 32'h0000F000);
    check("post rst valid",      32'(d0_valid), 32'(1));

    // Randomized traffic alternating write-heavy and read-heavy phases so both edges are reached.
    for (int c = 0; c < 600; c++) begin
      logic r, e, f, w, rq;
      bit   wr_heavy;
      wr_heavy = ((c / 40) % 2) == 0;
      r  = ($urandom_range(79) != 0);
      e  = ($urandom_range(7) != 0);
      f  = ($urandom_range(31) == 0);
      w  = wr_heavy ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      rq = wr_heavy ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      step($sformatf("rnd%0d", c), r, e, f, w, rq, 16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
